// File: rtl/step_sched_pkg.sv
// Shared encodings for the step scheduler: output phase and FSM state,
// plus the phase advance helper used by the datapath.
package step_sched_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10,
        THREE = 2'b11
    } phase_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Two-bit add wraps THREE back to ZERO for free.
    function automatic phase_e phase_inc(input phase_e p);
        logic [1:0] raw;
        raw = 2'(p) + 2'b01;
        return phase_e'(raw);
    endfunction

endpackage

// File: rtl/step_datapath.sv
// Phase counter and shift-pattern register for the step scheduler.
// clear wins over step; both flops hold when neither is asserted.
module step_datapath
    import step_sched_pkg::*;
#(
    parameter int SHIFT_W = 127
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               step,
    output logic [1:0]         phase,
    output logic [SHIFT_W-1:0] shift
);

    phase_e             phase_q, phase_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;

    always_comb begin
        phase_d = phase_q;
        shift_d = shift_q;
        if (clear) begin
            phase_d = ZERO;
            shift_d = '0;
        end else if (step) begin
            phase_d = phase_inc(phase_q);
            shift_d = {shift_q[SHIFT_W-3:0], 2'b11};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= ZERO;
            shift_q <= '0;
        end else begin
            phase_q <= phase_d;
            shift_q <= shift_d;
        end
    end

    assign phase = phase_q;
    assign shift = shift_q;

endmodule

// File: rtl/step_scheduler.sv
// Step scheduler: accepts a step-count command and issues that many handshaked
// steps. Define STEP_SCHEDULER_STATS_EN to add the saturating step_count port.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | presenting steps, one fires per out_valid && out_ready
// DONE  | one-cycle done pulse, commands refused
module step_scheduler
    import step_sched_pkg::*;
#(
    parameter int SHIFT_W = 127,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_phase,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               busy,
`ifdef STEP_SCHEDULER_STATS_EN
    output logic [15:0]        step_count,
`endif
    output logic               done
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             dp_clear;
    logic             dp_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // abort takes priority over a ready consumer, so the aborting cycle never steps.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dp_clear    = 1'b0;
        dp_step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        state_d     = RUN;
                        remaining_d = cmd_len;
                        dp_clear    = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = DONE;
                end else if (out_ready) begin
                    dp_step     = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by rst_n so the handshake stays quiet while reset is held.
    always_comb begin
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (rst_n) begin
            cmd_ready = (state_q == IDLE);
            out_valid = (state_q == RUN);
            busy      = (state_q == RUN) || (state_q == DONE);
            done      = (state_q == DONE);
        end
    end

    step_datapath #(
        .SHIFT_W (SHIFT_W)
    ) u_datapath (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (dp_clear),
        .step  (dp_step),
        .phase (out_phase),
        .shift (out_shift)
    );

`ifdef STEP_SCHEDULER_STATS_EN
    logic [15:0] step_count_q, step_count_d;

    always_comb begin
        step_count_d = step_count_q;
        if (dp_step && (step_count_q != 16'hFFFF)) begin
            step_count_d = step_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_count_q <= '0;
        end else begin
            step_count_q <= step_count_d;
        end
    end

    assign step_count = step_count_q;
`endif

endmodule

// File: tb/tb_step_scheduler.sv
// Self-checking bench for step_scheduler; the reference model tracks only the
// number of steps fired, from which phase (n mod 4) and shift (2n low ones) follow.
module tb_step_scheduler;

    localparam int SHIFT_W = 127;
    localparam int LEN_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [LEN_W-1:0]   cmd_len;
    logic               abort;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_phase;
    logic [SHIFT_W-1:0] out_shift;
    logic               busy;
    logic               done;
`ifdef STEP_SCHEDULER_STATS_EN
    logic [15:0]        step_count;
`endif

    int total = 0;
    int bad   = 0;
    int m_steps = 0;
    int m_fired = 0;

    always #5 clk = ~clk;

    step_scheduler #(
        .SHIFT_W (SHIFT_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_phase  (out_phase),
        .out_shift  (out_shift),
        .busy       (busy),
`ifdef STEP_SCHEDULER_STATS_EN
        .step_count (step_count),
`endif
        .done       (done)
    );

    function automatic logic [SHIFT_W-1:0] exp_shift(input int n);
        logic [SHIFT_W-1:0] ones;
        ones = '1;
        if (2 * n >= SHIFT_W) return ones;
        return ones >> (SHIFT_W - 2 * n);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one command and follows it to IDLE, checking every cycle against the model.
    // ready_mode: 0 always ready, 1 toggling starting ready, 2 random.
    task automatic run_cmd(input int len, input int ready_mode, input int abort_after,
                           input string tag, output int steps_seen);
        int  rem;
        int  budget;
        int  cyc;
        logic rdy;
        logic ab;
        steps_seen = 0;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s idle_ready: cmd_ready=%b want 1", tag, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        tick;
        cmd_valid = 1'b0;
        cmd_len   = LEN_W'($urandom);
        if (len != 0) m_steps = 0;
        rem    = len;
        budget = 4 * len + 20;
        cyc    = 0;
        while (rem > 0 && budget > 0) begin
            total++;
            if (out_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0 ||
                out_phase !== 2'(m_steps % 4) || out_shift !== exp_shift(m_steps)) begin
                bad++;
                $display("FAIL %s run_cycle%0d: valid=%b done=%b busy=%b rdy=%b phase=%0d shift=%h want phase=%0d shift=%h",
                         tag, cyc, out_valid, done, busy, cmd_ready, out_phase, out_shift,
                         m_steps % 4, exp_shift(m_steps));
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ab        = (abort_after >= 0) && (steps_seen == abort_after);
            out_ready = rdy;
            abort     = ab;
            cmd_valid = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick;
            if (ab) begin
                rem = 0;
            end else if (rdy) begin
                m_steps++;
                m_fired++;
                steps_seen++;
                rem--;
            end
            cyc++;
            budget--;
        end
        out_ready = 1'b0;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        if (rem > 0) begin
            bad++;
            $display("FAIL %s budget: run did not finish, remaining=%0d want 0", tag, rem);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s done_state: done=%b busy=%b valid=%b rdy=%b want 1 1 0 0",
                     tag, done, busy, out_valid, cmd_ready);
        end
        // A command offered during DONE must be refused.
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(5);
        tick;
        cmd_valid = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1 ||
            out_phase !== 2'(m_steps % 4) || out_shift !== exp_shift(m_steps)) begin
            bad++;
            $display("FAIL %s after_done: done=%b busy=%b valid=%b rdy=%b phase=%0d shift=%h want 0 0 0 1 phase=%0d shift=%h",
                     tag, done, busy, out_valid, cmd_ready, out_phase, out_shift,
                     m_steps % 4, exp_shift(m_steps));
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        total++;
        if (cmd_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            out_phase !== 2'b00 || out_shift !== '0) begin
            bad++;
            $display("FAIL reset_hold: rdy=%b valid=%b busy=%b done=%b phase=%0d shift=%h want all zero",
                     cmd_ready, out_valid, busy, done, out_phase, out_shift);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: cmd_ready=%b want 1", cmd_ready);
        end
        m_steps = 0;
        m_fired = 0;
    endtask

    task automatic test_basic;
        int n;
        run_cmd(3, 0, -1, "basic", n);
        total++;
        if (n != 3 || out_phase !== 2'b11 || out_shift !== 127'h3F) begin
            bad++;
            $display("FAIL basic_final: steps=%0d phase=%0d shift=%h want 3 3 3f", n, out_phase, out_shift);
        end
    endtask

    task automatic test_stall;
        int n;
        run_cmd(5, 1, -1, "stall", n);
        total++;
        if (n != 5 || out_phase !== 2'b01 || out_shift !== 127'h3FF) begin
            bad++;
            $display("FAIL stall_final: steps=%0d phase=%0d shift=%h want 5 1 3ff", n, out_phase, out_shift);
        end
    endtask

    task automatic test_zero_len;
        int n;
        run_cmd(0, 0, -1, "zero_len", n);
        total++;
        if (n != 0 || out_phase !== 2'b01 || out_shift !== 127'h3FF) begin
            bad++;
            $display("FAIL zero_len_hold: steps=%0d phase=%0d shift=%h want 0 1 3ff", n, out_phase, out_shift);
        end
    endtask

    task automatic test_abort;
        int n;
        run_cmd(10, 0, 4, "abort", n);
        total++;
        if (n != 4 || out_phase !== 2'b00 || out_shift !== 127'hFF) begin
            bad++;
            $display("FAIL abort_final: steps=%0d phase=%0d shift=%h want 4 0 ff", n, out_phase, out_shift);
        end
    endtask

    task automatic test_long_and_reset;
        int n;
        logic [SHIFT_W-1:0] ones;
        ones = '1;
        run_cmd(70, 0, -1, "long", n);
        total++;
        if (n != 70 || out_phase !== 2'b10 || out_shift !== ones) begin
            bad++;
            $display("FAIL long_final: steps=%0d phase=%0d shift=%h want 70 2 all-ones", n, out_phase, out_shift);
        end
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(70);
        tick;
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick;
        rst_n = 1'b0;
        tick;
        total++;
        if (cmd_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            out_phase !== 2'b00 || out_shift !== '0) begin
            bad++;
            $display("FAIL midrun_reset: rdy=%b valid=%b busy=%b done=%b phase=%0d shift=%h want all zero",
                     cmd_ready, out_valid, busy, done, out_phase, out_shift);
        end
        rst_n = 1'b1;
        #1;
        m_steps = 0;
        m_fired = 0;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrun_release: cmd_ready=%b want 1", cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if (done !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                bad++;
                $display("FAIL post_reset_quiet: done=%b valid=%b rdy=%b want 0 0 1", done, out_valid, cmd_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_max_len;
        int n;
        logic [SHIFT_W-1:0] ones;
        ones = '1;
        run_cmd(255, 0, -1, "max_len", n);
        total++;
        if (n != 255 || out_phase !== 2'b11 || out_shift !== ones) begin
            bad++;
            $display("FAIL max_len_final: steps=%0d phase=%0d shift=%h want 255 3 all-ones", n, out_phase, out_shift);
        end
    endtask

    task automatic test_random;
        int n;
        int len;
        int ab;
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(0, 40);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
            for (int k = 0; k < 2; k++) begin
                abort = 1'($urandom_range(0, 1));
                tick;
                total++;
                if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_idle: rdy=%b busy=%b done=%b want 1 0 0", cmd_ready, busy, done);
                end
            end
            abort = 1'b0;
            run_cmd(len, 2, ab, "random", n);
        end
    endtask

`ifdef STEP_SCHEDULER_STATS_EN
    task automatic test_stats;
        int n;
        total++;
        if (step_count !== 16'(m_fired)) begin
            bad++;
            $display("FAIL stats_running: step_count=%0d want %0d", step_count, m_fired);
        end
        test_reset;
        run_cmd(3, 0, -1, "stats3", n);
        run_cmd(5, 1, -1, "stats5", n);
        total++;
        if (step_count !== 16'd8) begin
            bad++;
            $display("FAIL stats_8: step_count=%0d want 8", step_count);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_zero_len;
        test_abort;
        test_long_and_reset;
        test_max_len;
        test_random;
`ifdef STEP_SCHEDULER_STATS_EN
        test_stats;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
